calc_op_sequencer: RTL and testbench

//   Synchronous front-end controller for the Basys-3 calculator.
//   - Samples the nine push-buttons and keeps the two 2-digit BCD operands.
//   - Issues one operation at a time to a multi-cycle arithmetic unit over a start/done handshake.
//   - Latches the result and error flags, and selects whether the display shows operands or result.
//   - Sits between the raw button pins and the ALU / seven-segment mux.
//   - All state is clocked on clk; no button signal is used as a clock.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/btn_sync_edge.sv | 32 +++
 rtl/calc_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants, state encoding and small helpers for the calculator front-end.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int NUM_BTN   = 9;
    localparam int BTN_CLEAR = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    // BCD digit increment, 9 wraps back to 0
    function automatic logic [3:0] incDigit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Two BCD digits to binary; 99 is the largest value so 7 bits never overflow
    function automatic logic [6:0] bcdToBin(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    // Operation buttons B5..B8; the lowest index wins when several arrive together
    function automatic logic [1:0] opPriority(input logic [3:0] ops);
        if (ops[0]) return OP_ADD;
        if (ops[1]) return OP_SUB;
        if (ops[2]) return OP_MUL;
        return OP_DIV;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Brings one asynchronous button into the clk domain and emits a single-cycle
// pulse on each rising edge. The pulse itself is registered, so a press shows
// up SYNC_STAGES+1 cycles after the pin goes high.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    // Synchronizer chain, previous-value flop and registered rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator front-end: button pulses edit the BCD operands and launch one ALU
// operation at a time over a start/done handshake, with a timeout abort and
// latched result/error flags that drive the display selection.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RES_W          = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       btn,
    output logic             alu_start,
    output logic [1:0]       alu_op,
    output logic [6:0]       alu_a,
    output logic [6:0]       alu_b,
    input  logic             alu_done,
    input  logic [RES_W-1:0] alu_result,
    input  logic             alu_neg,
    input  logic             alu_div0,
    output logic [3:0]       a_tens,
    output logic [3:0]       a_units,
    output logic [3:0]       b_tens,
    output logic [3:0]       b_units,
    output logic [RES_W-1:0] res_q,
    output logic             res_neg,
    output logic             res_err,
    output logic             show_result,
    output logic             busy
);

    // The counter is loaded with TIMEOUT_CYCLES-1 so that the abort decision
    // lands on the TIMEOUT_CYCLES-th edge after alu_start
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [NUM_BTN-1:0] pulse;

    state_t             state_q,  state_d;
    logic [3:0]         aTens_q,  aTens_d;
    logic [3:0]         aUnits_q, aUnits_d;
    logic [3:0]         bTens_q,  bTens_d;
    logic [3:0]         bUnits_q, bUnits_d;
    logic [1:0]         op_q,     op_d;
    logic [6:0]         aluA_q,   aluA_d;
    logic [6:0]         aluB_q,   aluB_d;
    logic [TW-1:0]      timer_q,  timer_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               resNeg_q, resNeg_d;
    logic               resErr_q, resErr_d;
    logic               show_q,   show_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (btn[i]),
            .pulse(pulse[i])
        );
    end

    // All controller state; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            aTens_q  <= '0;
            aUnits_q <= '0;
            bTens_q  <= '0;
            bUnits_q <= '0;
            op_q     <= OP_ADD;
            aluA_q   <= '0;
            aluB_q   <= '0;
            timer_q  <= '0;
            result_q <= '0;
            resNeg_q <= 1'b0;
            resErr_q <= 1'b0;
            show_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            aTens_q  <= aTens_d;
            aUnits_q <= aUnits_d;
            bTens_q  <= bTens_d;
            bUnits_q <= bUnits_d;
            op_q     <= op_d;
            aluA_q   <= aluA_d;
            aluB_q   <= aluB_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            resNeg_q <= resNeg_d;
            resErr_q <= resErr_d;
            show_q   <= show_d;
        end
    end

    // Next state: clear overrides everything, digits override ops, WAIT ignores all but clear
    always_comb begin
        state_d  = state_q;
        aTens_d  = aTens_q;
        aUnits_d = aUnits_q;
        bTens_d  = bTens_q;
        bUnits_d = bUnits_q;
        op_d     = op_q;
        aluA_d   = aluA_q;
        aluB_d   = aluB_q;
        timer_d  = timer_q;
        result_d = result_q;
        resNeg_d = resNeg_q;
        resErr_d = resErr_q;
        show_d   = show_q;

        if (pulse[BTN_CLEAR]) begin
            state_d  = S_IDLE;
            result_d = '0;
            resNeg_d = 1'b0;
            resErr_d = 1'b0;
            show_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_SHOW: begin
                    if (|pulse[3:0]) begin
                        if (pulse[0]) aTens_d  = incDigit(aTens_q);
                        if (pulse[1]) aUnits_d = incDigit(aUnits_q);
                        if (pulse[2]) bTens_d  = incDigit(bTens_q);
                        if (pulse[3]) bUnits_d = incDigit(bUnits_q);
                        show_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (|pulse[7:4]) begin
                        op_d    = opPriority(pulse[7:4]);
                        aluA_d  = bcdToBin(aTens_q, aUnits_q);
                        aluB_d  = bcdToBin(bTens_q, bUnits_q);
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_d = TIMEOUT_LOAD;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        result_d = alu_result;
                        resNeg_d = alu_neg;
                        resErr_d = alu_div0;
                        show_d   = 1'b1;
                        state_d  = S_SHOW;
                    end else if (timer_q == '0) begin
                        result_d = '0;
                        resNeg_d = 1'b0;
                        resErr_d = 1'b1;
                        show_d   = 1'b1;
                        state_d  = S_SHOW;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign alu_start   = (state_q == S_ISSUE);
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign alu_op      = op_q;
    assign alu_a       = aluA_q;
    assign alu_b       = aluB_q;
    assign a_tens      = aTens_q;
    assign a_units     = aUnits_q;
    assign b_tens      = bTens_q;
    assign b_units     = bUnits_q;
    assign res_q       = result_q;
    assign res_neg     = resNeg_q;
    assign res_err     = resErr_q;
    assign show_result = show_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: the bench plays buttons and ALU,
// keeps its own operand model and a queue of expected ALU requests.
`timescale 1ns/1ps
module tb_calc_op_sequencer;
    import calc_pkg::*;

    localparam int RES_W = 14;
    localparam int TOUT  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [8:0]       btn = '0;
    logic             alu_done = 1'b0;
    logic [RES_W-1:0] alu_result = '0;
    logic             alu_neg = 1'b0;
    logic             alu_div0 = 1'b0;
    logic             alu_start;
    logic [1:0]       alu_op;
    logic [6:0]       alu_a, alu_b;
    logic [3:0]       a_tens, a_units, b_tens, b_units;
    logic [RES_W-1:0] res_q;
    logic             res_neg, res_err, show_result, busy;

    typedef struct {
        logic [1:0] op;
        logic [6:0] a;
        logic [6:0] b;
    } issue_t;

    issue_t expQ[$];
    issue_t obsArr[64];
    int     obsWr = 0;
    int     obsRd = 0;
    int     nCompared = 0;
    int     nMismatched = 0;
    logic [3:0] mAT = '0, mAU = '0, mBT = '0, mBU = '0;

    calc_op_sequencer #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TOUT),
        .RES_W         (RES_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_neg    (alu_neg),
        .alu_div0   (alu_div0),
        .a_tens     (a_tens),
        .a_units    (a_units),
        .b_tens     (b_tens),
        .b_units    (b_units),
        .res_q      (res_q),
        .res_neg    (res_neg),
        .res_err    (res_err),
        .show_result(show_result),
        .busy       (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Records every ALU request seen by the DUT, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && alu_start && obsWr < 64) begin
            obsArr[obsWr] = '{alu_op, alu_a, alu_b};
            obsWr = obsWr + 1;
        end
    end

    // Hard stop so a stuck bench still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [3:0] nextDigit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic int modelA();
        return int'(mAT) * 10 + int'(mAU);
    endfunction

    function automatic int modelB();
        return int'(mBT) * 10 + int'(mBU);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press and release a set of buttons; the DUT has acted on the press on return
    task automatic applyStimulus(input logic [8:0] mask);
        btn = mask;
        repeat (2) tick();
        btn = '0;
        repeat (2) tick();
    endtask

    task automatic pushIssue(input logic [1:0] op);
        expQ.push_back('{op, 7'(modelA()), 7'(modelB())});
    endtask

    task automatic waitStart(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (alu_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic aluRespond(input int delay, input int res, input logic neg, input logic div0);
        repeat (delay) tick();
        alu_result = RES_W'(res);
        alu_neg    = neg;
        alu_div0   = div0;
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        alu_result = '0;
        alu_neg    = 1'b0;
        alu_div0   = 1'b0;
    endtask

    // Steps the digit buttons (several at once where possible) until the operands match
    task automatic setOperands(input logic [3:0] at, input logic [3:0] au,
                               input logic [3:0] bt, input logic [3:0] bu);
        logic [8:0] mask;
        for (int n = 0; n < 10; n++) begin
            mask = '0;
            mask[0] = (mAT != at);
            mask[1] = (mAU != au);
            mask[2] = (mBT != bt);
            mask[3] = (mBU != bu);
            if (mask == '0) break;
            applyStimulus(mask);
            if (mask[0]) mAT = nextDigit(mAT);
            if (mask[1]) mAU = nextDigit(mAU);
            if (mask[2]) mBT = nextDigit(mBT);
            if (mask[3]) mBU = nextDigit(mBU);
        end
    endtask

    task automatic test_reset();
        bit seen;
        issue_t ex;
        rst = 1'b1;
        repeat (3) tick();
        nCompared++;
        if ({a_tens, a_units, b_tens, b_units} !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_digits: got %h, required 0000", {a_tens, a_units, b_tens, b_units}); end
        nCompared++;
        if ({alu_start, alu_op, alu_a, alu_b} !== 17'h0) begin nMismatched++; $display("[TB] FAIL reset_alu_if: got start=%0d op=%0d a=%0d b=%0d, required all 0", alu_start, alu_op, alu_a, alu_b); end
        nCompared++;
        if ({res_q, res_neg, res_err, show_result, busy} !== 18'h0) begin nMismatched++; $display("[TB] FAIL reset_result: got res=%0d neg=%0d err=%0d show=%0d busy=%0d, required all 0", res_q, res_neg, res_err, show_result, busy); end
        rst = 1'b0;
        tick();

        pushIssue(OP_ADD);
        applyStimulus(9'h010);
        waitStart(seen);
        nCompared++;
        if (seen !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_start_seen: got no alu_start, required one"); end
        repeat (2) tick();
        nCompared++;
        if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_wait_busy: got busy=%0d, required 1", busy); end
        rst = 1'b1;
        #1;
        nCompared++;
        if ({busy, alu_start, show_result} !== 3'b000) begin nMismatched++; $display("[TB] FAIL rst_async_abort: got busy=%0d start=%0d show=%0d, required 0", busy, alu_start, show_result); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        alu_result = RES_W'(77);
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        alu_result = '0;
        tick();
        nCompared++;
        if ({res_q, res_err, show_result, busy} !== 17'h0) begin nMismatched++; $display("[TB] FAIL rst_late_done: got res=%0d err=%0d show=%0d busy=%0d, required all 0", res_q, res_err, show_result, busy); end

        ex = expQ.pop_front();
        nCompared++;
        if (obsWr != obsRd + 1) begin nMismatched++; $display("[TB] FAIL rst_issue_count: got %0d requests, required 1", obsWr - obsRd); end
        else if ({obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b} !== {ex.op, ex.a, ex.b}) begin nMismatched++; $display("[TB] FAIL rst_issue: got op=%0d a=%0d b=%0d, required op=%0d a=%0d b=%0d", obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b, ex.op, ex.a, ex.b); end
        obsRd = obsWr;
    endtask

    task automatic test_multiply();
        bit seen;
        issue_t ex;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(9'h001);
            mAT = nextDigit(mAT);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(9'h008);
            mBU = nextDigit(mBU);
        end
        nCompared++;
        if ({a_tens, a_units, b_tens, b_units} !== 16'h2003) begin nMismatched++; $display("[TB] FAIL mul_digits: got %h, required 2003", {a_tens, a_units, b_tens, b_units}); end

        pushIssue(OP_MUL);
        applyStimulus(9'h040);
        waitStart(seen);
        nCompared++;
        if (seen !== 1'b1) begin nMismatched++; $display("[TB] FAIL mul_start_seen: got no alu_start, required one"); end
        aluRespond(5, modelA() * modelB(), 1'b0, 1'b0);
        nCompared++;
        if ({res_q, res_neg, res_err, show_result, busy} !== {14'd60, 4'b0010}) begin nMismatched++; $display("[TB] FAIL mul_result: got res=%0d neg=%0d err=%0d show=%0d busy=%0d, required res=60 show=1", res_q, res_neg, res_err, show_result, busy); end

        ex = expQ.pop_front();
        nCompared++;
        if (obsWr != obsRd + 1) begin nMismatched++; $display("[TB] FAIL mul_issue_count: got %0d requests, required 1", obsWr - obsRd); end
        else if ({obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b} !== {2'd2, 7'd20, 7'd3} || ex.a !== 7'd20) begin nMismatched++; $display("[TB] FAIL mul_issue: got op=%0d a=%0d b=%0d, required op=2 a=20 b=3", obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b); end
        obsRd = obsWr;
    endtask

    task automatic test_back_to_back();
        bit seen;
        issue_t ex;
        setOperands(4'd1, 4'd5, 4'd2, 4'd7);
        nCompared++;
        if ({a_tens, a_units, b_tens, b_units, show_result} !== {16'h1527, 1'b0}) begin nMismatched++; $display("[TB] FAIL b2b_digits: got %h show=%0d, required 1527 show=0", {a_tens, a_units, b_tens, b_units}, show_result); end

        pushIssue(OP_ADD);
        applyStimulus(9'h0B0);
        waitStart(seen);
        nCompared++;
        if (seen !== 1'b1 || alu_op !== OP_ADD) begin nMismatched++; $display("[TB] FAIL b2b_priority: got seen=%0d op=%0d, required seen=1 op=0", seen, alu_op); end
        applyStimulus(9'h020);
        applyStimulus(9'h041);
        nCompared++;
        if ({busy, a_tens} !== {1'b1, 4'd1}) begin nMismatched++; $display("[TB] FAIL b2b_wait_ignore: got busy=%0d a_tens=%0d, required busy=1 a_tens=1", busy, a_tens); end
        aluRespond(1, modelA() + modelB(), 1'b0, 1'b0);
        nCompared++;
        if ({res_q, show_result} !== {14'd42, 1'b1}) begin nMismatched++; $display("[TB] FAIL b2b_result: got res=%0d show=%0d, required res=42 show=1", res_q, show_result); end

        ex = expQ.pop_front();
        nCompared++;
        if (obsWr != obsRd + 1) begin nMismatched++; $display("[TB] FAIL b2b_issue_count: got %0d requests, required 1", obsWr - obsRd); end
        else if ({obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b} !== {ex.op, ex.a, ex.b}) begin nMismatched++; $display("[TB] FAIL b2b_issue: got op=%0d a=%0d b=%0d, required op=%0d a=%0d b=%0d", obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b, ex.op, ex.a, ex.b); end
        obsRd = obsWr;
    endtask

    task automatic test_div_zero();
        bit seen;
        issue_t ex;
        setOperands(4'd4, 4'd2, 4'd0, 4'd0);
        pushIssue(OP_DIV);
        applyStimulus(9'h080);
        waitStart(seen);
        nCompared++;
        if (seen !== 1'b1) begin nMismatched++; $display("[TB] FAIL div_start_seen: got no alu_start, required one"); end
        aluRespond(3, 0, 1'b0, 1'b1);
        nCompared++;
        if ({res_err, show_result, res_q} !== {2'b11, 14'd0}) begin nMismatched++; $display("[TB] FAIL div0_latch: got err=%0d show=%0d res=%0d, required err=1 show=1 res=0", res_err, show_result, res_q); end
        applyStimulus(9'h002);
        mAU = nextDigit(mAU);
        nCompared++;
        if ({a_units, show_result, res_err, busy} !== {mAU, 3'b010}) begin nMismatched++; $display("[TB] FAIL div0_digit: got a_units=%0d show=%0d err=%0d busy=%0d, required a_units=%0d show=0 err=1 busy=0", a_units, show_result, res_err, busy, mAU); end

        ex = expQ.pop_front();
        nCompared++;
        if (obsWr != obsRd + 1) begin nMismatched++; $display("[TB] FAIL div_issue_count: got %0d requests, required 1", obsWr - obsRd); end
        else if ({obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b} !== {ex.op, ex.a, ex.b}) begin nMismatched++; $display("[TB] FAIL div_issue: got op=%0d a=%0d b=%0d, required op=%0d a=%0d b=%0d", obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b, ex.op, ex.a, ex.b); end
        obsRd = obsWr;
    endtask

    task automatic test_timeout();
        bit seen;
        issue_t ex;
        int diff;
        applyStimulus(9'h100);
        nCompared++;
        if ({res_err, show_result, res_q, a_tens, a_units} !== {2'b00, 14'd0, mAT, mAU}) begin nMismatched++; $display("[TB] FAIL clear_idle: got err=%0d show=%0d res=%0d a=%0d%0d, required err=0 show=0 res=0 a=%0d%0d", res_err, show_result, res_q, a_tens, a_units, mAT, mAU); end

        setOperands(4'd1, 4'd2, 4'd3, 4'd4);
        pushIssue(OP_ADD);
        applyStimulus(9'h010);
        waitStart(seen);
        tick();
        repeat (TOUT - 1) tick();
        nCompared++;
        if ({seen, res_err, busy} !== 3'b101) begin nMismatched++; $display("[TB] FAIL timeout_early: got seen=%0d err=%0d busy=%0d at edge 15, required seen=1 err=0 busy=1", seen, res_err, busy); end
        tick();
        nCompared++;
        if ({res_err, show_result, res_q, res_neg, busy} !== {2'b11, 14'd0, 2'b00}) begin nMismatched++; $display("[TB] FAIL timeout_expire: got err=%0d show=%0d res=%0d neg=%0d busy=%0d at edge 16, required err=1 show=1 res=0", res_err, show_result, res_q, res_neg, busy); end

        ex = expQ.pop_front();
        nCompared++;
        if (obsWr != obsRd + 1) begin nMismatched++; $display("[TB] FAIL tout_issue_count: got %0d requests, required 1", obsWr - obsRd); end
        else if ({obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b} !== {ex.op, ex.a, ex.b}) begin nMismatched++; $display("[TB] FAIL tout_issue: got op=%0d a=%0d b=%0d, required op=%0d a=%0d b=%0d", obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b, ex.op, ex.a, ex.b); end
        obsRd = obsWr;

        pushIssue(OP_SUB);
        applyStimulus(9'h020);
        waitStart(seen);
        tick();
        repeat (TOUT - 1) tick();
        diff = modelA() - modelB();
        alu_result = RES_W'((diff < 0) ? -diff : diff);
        alu_neg    = (diff < 0);
        alu_div0   = 1'b0;
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        alu_result = '0;
        alu_neg    = 1'b0;
        nCompared++;
        if ({seen, res_err, res_neg, show_result, res_q} !== {4'b1011, 14'd22}) begin nMismatched++; $display("[TB] FAIL done_beats_timeout: got seen=%0d err=%0d neg=%0d show=%0d res=%0d, required err=0 neg=1 show=1 res=22", seen, res_err, res_neg, show_result, res_q); end

        ex = expQ.pop_front();
        nCompared++;
        if (obsWr != obsRd + 1) begin nMismatched++; $display("[TB] FAIL sub_issue_count: got %0d requests, required 1", obsWr - obsRd); end
        else if ({obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b} !== {ex.op, ex.a, ex.b}) begin nMismatched++; $display("[TB] FAIL sub_issue: got op=%0d a=%0d b=%0d, required op=%0d a=%0d b=%0d", obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b, ex.op, ex.a, ex.b); end
        obsRd = obsWr;
    endtask

    task automatic test_clear_wait();
        bit seen;
        issue_t ex;
        pushIssue(OP_MUL);
        applyStimulus(9'h040);
        waitStart(seen);
        repeat (2) tick();
        nCompared++;
        if ({seen, busy} !== 2'b11) begin nMismatched++; $display("[TB] FAIL clr_wait_busy: got seen=%0d busy=%0d, required 1 1", seen, busy); end
        applyStimulus(9'h100);
        nCompared++;
        if ({busy, alu_start, show_result, res_neg, res_q} !== {4'b0000, 14'd0}) begin nMismatched++; $display("[TB] FAIL clr_wait_abort: got busy=%0d start=%0d show=%0d neg=%0d res=%0d, required all 0", busy, alu_start, show_result, res_neg, res_q); end
        aluRespond(1, 99, 1'b0, 1'b0);
        tick();
        nCompared++;
        if ({res_q, show_result, busy} !== {14'd0, 2'b00}) begin nMismatched++; $display("[TB] FAIL clr_late_done: got res=%0d show=%0d busy=%0d, required res=0 show=0 busy=0", res_q, show_result, busy); end

        ex = expQ.pop_front();
        nCompared++;
        if (obsWr != obsRd + 1) begin nMismatched++; $display("[TB] FAIL clr_issue_count: got %0d requests, required 1", obsWr - obsRd); end
        else if ({obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b} !== {ex.op, ex.a, ex.b}) begin nMismatched++; $display("[TB] FAIL clr_issue: got op=%0d a=%0d b=%0d, required op=%0d a=%0d b=%0d", obsArr[obsRd].op, obsArr[obsRd].a, obsArr[obsRd].b, ex.op, ex.a, ex.b); end
        obsRd = obsWr;
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_multiply();
        test_back_to_back();
        test_div_zero();
        test_timeout();
        test_clear_wait();
        nCompared++;
        if (expQ.size() != 0 || obsWr != obsRd) begin nMismatched++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected and %0d unchecked requests, required 0 and 0", expQ.size(), obsWr - obsRd); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
